// File: rtl/ray_column_writer.sv
// Expands one DDA column result into SCREEN_HEIGHT ceiling/wall/floor RGB565 frame-buffer writes.
// Registered pixel stream with valid/ready; the next column is accepted only after the last row is taken.
module ray_column_writer #(
    parameter int          SCREEN_WIDTH  = 320,
    parameter int          SCREEN_HEIGHT = 240,
    parameter int          ADDR_WIDTH    = 17,
    parameter logic [15:0] CEIL_COLOR    = 16'h39E7,
    parameter logic [15:0] FLOOR_COLOR   = 16'h6B4D
) (
    input  logic                  pixel_clk_in,
    input  logic                  rst_in,
    input  logic                  dda_tvalid_in,
    input  logic [38:0]           dda_tdata_in,
    input  logic                  dda_tlast_in,
    output logic                  dda_tready_out,
    output logic                  pixel_valid_out,
    input  logic                  pixel_ready_in,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic [15:0]           pixel_out,
    output logic                  last_pixel_out,
    output logic [7:0]            drop_count_out
);

    localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam int HW = $clog2(SCREEN_HEIGHT + 1);
    localparam logic [YW-1:0]         Y_LAST     = YW'(SCREEN_HEIGHT - 1);
    localparam logic [HW-1:0]         ROWS       = HW'(SCREEN_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(SCREEN_WIDTH);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t                state_q, state_n;
    logic                  tready_q, tready_n;
    logic                  valid_q, valid_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [15:0]           pix_q, pix_n;
    logic                  last_q, last_n;
    logic [7:0]            drop_q, drop_n;
    logic [YW-1:0]         y_q, y_n;
    logic [HW-1:0]         start_q, start_n;
    logic [HW-1:0]         lim_q, lim_n;
    logic [15:0]           wall_q, wall_n;
    logic                  tlast_q, tlast_n;

    logic [8:0]  beat_hcount;
    logic [8:0]  beat_lh;
    logic        beat_side;
    logic [3:0]  beat_type;
    logic        beat_drop;
    logic [HW-1:0] beat_lh_c, beat_start, beat_lim;
    logic [15:0] beat_pal, beat_wall;
    logic        accept, advance;
    logic        unused_bits;

    function automatic logic [15:0] palette(input logic [3:0] idx);
        case (idx)
            4'd0:    palette = 16'hFFFF;
            4'd1:    palette = 16'hF800;
            4'd2:    palette = 16'h07E0;
            4'd3:    palette = 16'h001F;
            4'd4:    palette = 16'hFFE0;
            4'd5:    palette = 16'hF81F;
            4'd6:    palette = 16'h07FF;
            4'd7:    palette = 16'h8410;
            4'd8:    palette = 16'hFC00;
            4'd9:    palette = 16'h8000;
            4'd10:   palette = 16'h0400;
            4'd11:   palette = 16'h0010;
            4'd12:   palette = 16'hA145;
            4'd13:   palette = 16'h52AA;
            4'd14:   palette = 16'hC618;
            default: palette = 16'h2104;
        endcase
    endfunction

    // Wall occupies rows [start, lim); lim == start when the column has no wall.
    function automatic logic [15:0] row_color(input logic [YW-1:0] y, input logic [HW-1:0] start,
                                              input logic [HW-1:0] lim, input logic [15:0] wall);
        if (HW'(y) < start)     row_color = CEIL_COLOR;
        else if (HW'(y) < lim)  row_color = wall;
        else                    row_color = FLOOR_COLOR;
    endfunction

    assign beat_hcount = dda_tdata_in[38:30];
    assign beat_lh     = dda_tdata_in[29:21];
    assign beat_side   = dda_tdata_in[20];
    assign beat_type   = dda_tdata_in[19:16];
    assign unused_bits = ^dda_tdata_in[15:0];

    assign beat_drop  = {1'b0, beat_hcount} >= 10'(SCREEN_WIDTH);
    assign beat_lh_c  = ({1'b0, beat_lh} >= 10'(SCREEN_HEIGHT)) ? ROWS : HW'(beat_lh);
    assign beat_start = (ROWS - beat_lh_c) >> 1;
    assign beat_lim   = beat_start + beat_lh_c;
    assign beat_pal   = palette(beat_type);
    assign beat_wall  = beat_side ? ((beat_pal >> 1) & 16'h7BEF) : beat_pal;

    assign accept  = dda_tvalid_in && tready_q;
    assign advance = valid_q && pixel_ready_in;

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            tready_q <= 1'b0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            pix_q    <= '0;
            last_q   <= 1'b0;
            drop_q   <= '0;
            y_q      <= '0;
            start_q  <= '0;
            lim_q    <= '0;
            wall_q   <= '0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            tready_q <= tready_n;
            valid_q  <= valid_n;
            addr_q   <= addr_n;
            pix_q    <= pix_n;
            last_q   <= last_n;
            drop_q   <= drop_n;
            y_q      <= y_n;
            start_q  <= start_n;
            lim_q    <= lim_n;
            wall_q   <= wall_n;
            tlast_q  <= tlast_n;
        end
    end

    always_comb begin
        state_n = state_q;
        valid_n = valid_q;
        addr_n  = addr_q;
        pix_n   = pix_q;
        last_n  = last_q;
        drop_n  = drop_q;
        y_n     = y_q;
        start_n = start_q;
        lim_n   = lim_q;
        wall_n  = wall_q;
        tlast_n = tlast_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (beat_drop) begin
                        if (drop_q != '1) drop_n = drop_q + 8'd1;
                    end else begin
                        state_n = DRAW;
                        y_n     = '0;
                        start_n = beat_start;
                        lim_n   = beat_lim;
                        wall_n  = beat_wall;
                        tlast_n = dda_tlast_in;
                        valid_n = 1'b1;
                        addr_n  = ADDR_WIDTH'(beat_hcount);
                        pix_n   = row_color('0, beat_start, beat_lim, beat_wall);
                        last_n  = dda_tlast_in && (Y_LAST == '0);
                    end
                end
            end
            DRAW: begin
                if (advance) begin
                    if (y_q == Y_LAST) begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        addr_n  = '0;
                        pix_n   = '0;
                        last_n  = 1'b0;
                    end else begin
                        y_n    = y_q + 1'b1;
                        addr_n = addr_q + ROW_STRIDE;
                        pix_n  = row_color(y_n, start_q, lim_q, wall_q);
                        last_n = tlast_q && (y_n == Y_LAST);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        tready_n = (state_n == IDLE);
    end

    assign dda_tready_out  = tready_q;
    assign pixel_valid_out = valid_q;
    assign address_out     = addr_q;
    assign pixel_out       = pix_q;
    assign last_pixel_out  = last_q;
    assign drop_count_out  = drop_q;

endmodule

// File: tb/tb_ray_column_writer.sv
// Bench for ray_column_writer: vector table of columns, corner sequences and random columns
// compared against a row-by-row model of the ceiling/wall/floor geometry.
module tb_ray_column_writer;

    localparam int          W     = 320;
    localparam int          H     = 240;
    localparam int          AW    = 17;
    localparam logic [15:0] CEIL  = 16'h39E7;
    localparam logic [15:0] FLOOR = 16'h6B4D;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          tvalid = 1'b0;
    logic [38:0]   tdata = '0;
    logic          tlast = 1'b0;
    logic          tready;
    logic          pvalid;
    logic          pready = 1'b1;
    logic [AW-1:0] addr;
    logic [15:0]   pix;
    logic          plast;
    logic [7:0]    drop;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cycles = 0;
    int drops_exp = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   p;
        logic          l;
    } px_t;
    px_t q[$];

    typedef struct {
        int h; int lh; bit side; int wt; bit tl; int mode;
        int n_ceil; int n_wall; int n_floor; logic [15:0] wcol;
    } vec_t;
    vec_t vecs[8];

    ray_column_writer #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_WIDTH(AW),
        .CEIL_COLOR(CEIL), .FLOOR_COLOR(FLOOR)
    ) dut (
        .pixel_clk_in(clk), .rst_in(rst_n),
        .dda_tvalid_in(tvalid), .dda_tdata_in(tdata), .dda_tlast_in(tlast), .dda_tready_out(tready),
        .pixel_valid_out(pvalid), .pixel_ready_in(pready),
        .address_out(addr), .pixel_out(pix), .last_pixel_out(plast), .drop_count_out(drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && pvalid) valid_cycles++;
        if (rst_n && pvalid && pready) q.push_back('{a: addr, p: pix, l: plast});
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pal_of(input int t);
        case (t)
            0: return 16'hFFFF;  1: return 16'hF800;  2: return 16'h07E0;  3: return 16'h001F;
            4: return 16'hFFE0;  5: return 16'hF81F;  6: return 16'h07FF;  7: return 16'h8410;
            8: return 16'hFC00;  9: return 16'h8000; 10: return 16'h0400; 11: return 16'h0010;
            12: return 16'hA145; 13: return 16'h52AA; 14: return 16'hC618; default: return 16'h2104;
        endcase
    endfunction

    // Darker side: halve each of the R, G and B channels independently.
    function automatic logic [15:0] shade(input logic [15:0] c);
        int r, g, b;
        r = int'(c[15:11]) / 2;
        g = int'(c[10:5]) / 2;
        b = int'(c[4:0]) / 2;
        return 16'(r * 2048 + g * 32 + b);
    endfunction

    function automatic logic [15:0] exp_color(input int y, input int lh, input bit side, input int wt);
        int lhc, ds;
        lhc = (lh > H) ? H : lh;
        ds = (H - lhc) / 2;
        if (y < ds) return CEIL;
        if (y < ds + lhc) return side ? shade(pal_of(wt)) : pal_of(wt);
        return FLOOR;
    endfunction

    task automatic start_beat(input int h, input int lh, input bit side, input int wt, input bit tl,
                              input int bound, output int acc, output bit ok);
        @(posedge clk); #1;
        tvalid = 1'b1;
        tdata  = {9'(h), 9'(lh), side, 4'(wt), 16'($urandom)};
        tlast  = tl;
        ok = 1'b0;
        acc = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tready) begin
                ok = 1'b1;
                acc = cyc;
                break;
            end
        end
    endtask

    task automatic drain(input int mode, input int h, input int lh, input bit side, input int wt,
                         output int hold_bad);
        bit stalled;
        stalled = 1'b0;
        hold_bad = 0;
        for (int c = 0; c < 5000 && q.size() < H; c++) begin
            @(posedge clk); #1;
            if (mode == 2) pready = ($urandom_range(0, 3) != 0);
            else if (mode == 1 && !stalled && q.size() == 10) begin
                stalled = 1'b1;
                pready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (!(pvalid === 1'b1 && addr === AW'(10 * W + h) && pix === exp_color(10, lh, side, wt)))
                        hold_bad++;
                end
                @(posedge clk); #1;
                pready = 1'b1;
            end
        end
        pready = 1'b1;
    endtask

    task automatic check_queue(input int h, input int lh, input bit side, input int wt, input bit tl);
        int bad;
        bad = 0;
        chk("pixel_count", q.size(), H);
        for (int y = 0; y < q.size() && y < H; y++) begin
            if (q[y].a !== AW'(y * W + h) || q[y].p !== exp_color(y, lh, side, wt) ||
                q[y].l !== (tl && y == H - 1)) begin
                if (bad == 0)
                    $display("  first bad row y=%0d addr=%0d pix=%h last=%b (h=%0d lh=%0d side=%0d type=%0d)",
                             y, q[y].a, q[y].p, q[y].l, h, lh, side, wt);
                bad++;
            end
        end
        chk("column_pixels", bad, 0);
    endtask

    task automatic run_column(input int h, input int lh, input bit side, input int wt, input bit tl,
                              input int mode);
        int acc, hold_bad;
        bit ok;
        q.delete();
        pready = 1'b1;
        start_beat(h, lh, side, wt, tl, 50, acc, ok);
        chk("beat_accepted", ok, 1);
        @(posedge clk); #1;
        tvalid = 1'b0;
        tlast = 1'b0;
        @(negedge clk);
        chk("tready_low_after_accept", tready, 0);
        chk("first_pixel_valid", pvalid, 1);
        drain(mode, h, lh, side, wt, hold_bad);
        if (mode == 1) chk("stall_hold", hold_bad, 0);
        @(negedge clk);
        chk("tready_after_column", tready, 1);
        chk("valid_after_column", pvalid, 0);
        check_queue(h, lh, side, wt, tl);
    endtask

    task automatic send_drops(input int n);
        int got;
        got = 0;
        @(posedge clk); #1;
        tvalid = 1'b1;
        tdata = {9'(320 + $urandom_range(0, 191)), 30'($urandom)};
        for (int i = 0; i < n * 4 && got < n; i++) begin
            @(negedge clk);
            if (tready) begin
                got++;
                @(posedge clk); #1;
                tdata = {9'(320 + $urandom_range(0, 191)), 30'($urandom)};
            end
        end
        tvalid = 1'b0;
        chk("drop_beats_accepted", got, n);
        drops_exp = (drops_exp + got > 255) ? 255 : drops_exp + got;
    endtask

    initial begin
        int base, c1, c2, nc, nw, nf, nl, lastaddr;
        bit ok;
        logic [15:0] wc;

        vecs[0] = '{0,   240, 1'b0, 1,  1'b0, 0, 0,   240, 0,   16'hF800};
        vecs[1] = '{5,   100, 1'b0, 2,  1'b0, 1, 70,  100, 70,  16'h07E0};
        vecs[2] = '{17,  400, 1'b1, 0,  1'b0, 0, 0,   240, 0,   16'h7BEF};
        vecs[3] = '{200, 0,   1'b0, 3,  1'b0, 0, 120, 0,   120, 16'h0000};
        vecs[4] = '{319, 239, 1'b1, 7,  1'b1, 0, 0,   239, 1,   16'h4208};
        vecs[5] = '{100, 1,   1'b0, 4,  1'b0, 2, 119, 1,   120, 16'hFFE0};
        vecs[6] = '{60,  241, 1'b0, 15, 1'b0, 0, 0,   240, 0,   16'h2104};
        vecs[7] = '{42,  99,  1'b1, 1,  1'b0, 2, 70,  99,  71,  16'h7800};

        // Reset state
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_tready", tready, 0);
        chk("reset_valid", pvalid, 0);
        chk("reset_addr", addr, 0);
        chk("reset_pixel", pix, 0);
        chk("reset_last", plast, 0);
        chk("reset_drop", drop, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_tready", tready, 1);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            run_column(vecs[i].h, vecs[i].lh, vecs[i].side, vecs[i].wt, vecs[i].tl, vecs[i].mode);
            nc = 0; nw = 0; nf = 0; nl = 0; wc = '0; lastaddr = -1;
            foreach (q[k]) begin
                if (q[k].p == CEIL) nc++;
                else if (q[k].p == FLOOR) nf++;
                else begin nw++; wc = q[k].p; end
                if (q[k].l) begin nl++; lastaddr = int'(q[k].a); end
            end
            chk("ceil_rows", nc, vecs[i].n_ceil);
            chk("wall_rows", nw, vecs[i].n_wall);
            chk("floor_rows", nf, vecs[i].n_floor);
            chk("wall_color", wc, vecs[i].wcol);
            chk("last_count", nl, int'(vecs[i].tl));
            if (vecs[i].tl) chk("last_addr", lastaddr, 76799);
        end

        // Back-to-back columns: one column every H+1 cycles
        q.delete();
        pready = 1'b1;
        start_beat(11, 120, 1'b0, 9, 1'b0, 50, c1, ok);
        chk("b2b_first_accept", ok, 1);
        start_beat(12, 30, 1'b1, 12, 1'b0, 300, c2, ok);
        chk("b2b_second_accept", ok, 1);
        chk("column_period", c2 - c1, H + 1);
        check_queue(11, 120, 1'b0, 9, 1'b0);
        q.delete();
        @(posedge clk); #1 tvalid = 1'b0;
        drain(0, 12, 30, 1'b1, 12, base);
        check_queue(12, 30, 1'b1, 12, 1'b0);

        // Random columns with random output back-pressure
        for (int i = 0; i < 5; i++) begin
            int h, lh, wt;
            bit side, tl;
            h = $urandom_range(0, W - 1);
            lh = ($urandom_range(0, 1) == 1) ? $urandom_range(0, H) : $urandom_range(0, 511);
            side = 1'($urandom_range(0, 1));
            wt = $urandom_range(0, 15);
            tl = 1'($urandom_range(0, 1));
            run_column(h, lh, side, wt, tl, 2);
        end

        // Out-of-range hcount beats are consumed and counted, never drawn
        q.delete();
        base = valid_cycles;
        send_drops(1);
        repeat (3) @(negedge clk);
        chk("drop_one", drop, drops_exp);
        chk("drop_no_pixels", valid_cycles - base, 0);
        send_drops(300);
        repeat (3) @(negedge clk);
        chk("drop_saturate", drop, 255);
        chk("drop_model", drop, drops_exp);
        chk("drop_tready", tready, 1);
        chk("drop_no_pixels_bulk", valid_cycles - base, 0);

        // Reset in the middle of a column abandons it
        q.delete();
        start_beat(7, 240, 1'b0, 5, 1'b1, 50, c1, ok);
        chk("midreset_accept", ok, 1);
        @(posedge clk); #1 tvalid = 1'b0;
        tlast = 1'b0;
        for (int i = 0; i < 2000 && q.size() < 50; i++) @(negedge clk);
        chk("midreset_row50", q.size(), 50);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("midreset_valid", pvalid, 0);
        chk("midreset_addr", addr, 0);
        chk("midreset_pixel", pix, 0);
        chk("midreset_last", plast, 0);
        chk("midreset_tready", tready, 0);
        chk("midreset_drop", drop, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = valid_cycles;
        repeat (300) @(negedge clk);
        chk("postreset_no_pixels", valid_cycles - base, 0);
        chk("postreset_tready", tready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
